// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared fetch-state encoding and reset-PC default
// Revision 1.0
// ============================================================================
package fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_REQ   = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : prefetch FIFO holding {pc, instr}; flush dominates push/pop
// Revision 1.0
// ============================================================================
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && (count != DEPTH_C);
   assign do_pop    = pop && (count != '0);
   assign head_data = mem[rd_ptr];

   // Storage is cleared on reset so the presented head reads zero when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, single-outstanding imem requester and decode feeder
// Revision 1.0
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int             XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
   parameter int             FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr
);

   localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   fetch_pc_nxt;
   logic [XLEN-1:0]   req_pc;
   logic [CNT_W-1:0]  count;
   logic [2*XLEN-1:0] head;
   logic              req_hs;
   logic              push;
   logic              pop;
   logic              flush;
   logic              unused_redirect_lsbs;

   // Redirect targets are forced word-aligned; the dropped bits are intentionally ignored.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign imem_req_valid = (state == FETCH_REQ) && !halt && !redirect_valid && (count < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign out_valid      = (count != '0) && !redirect_valid;
   assign pop            = out_valid && out_ready;
   assign out_pc         = head[2*XLEN-1:XLEN];
   assign out_instr      = head[XLEN-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FETCH_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (req_hs) req_pc <= fetch_pc;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      push         = 1'b0;
      flush        = 1'b0;
      if (redirect_valid) begin
         flush        = 1'b1;
         fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
         // An in-flight response still has to be swallowed before refetching.
         if ((state == FETCH_WAIT || state == FETCH_DRAIN) && !imem_rsp_valid)
            state_nxt = FETCH_DRAIN;
         else
            state_nxt = FETCH_REQ;
      end else begin
         case (state)
            FETCH_REQ: begin
               if (req_hs) begin
                  state_nxt    = FETCH_WAIT;
                  fetch_pc_nxt = fetch_pc + XLEN'(4);
               end
            end
            FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  push      = 1'b1;
                  state_nxt = FETCH_REQ;
               end
            end
            FETCH_DRAIN: begin
               if (imem_rsp_valid) state_nxt = FETCH_REQ;
            end
            default: state_nxt = FETCH_REQ;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({req_pc, imem_rsp_data}),
      .pop       (pop),
      .flush     (flush),
      .head_data (head),
      .count     (count)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench with a latency-programmable memory model
// Revision 1.0
// ============================================================================
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_req[$];
   logic [63:0] exp_out[$];

   int          mem_lat     = 1;
   bit          mem_pending = 0;
   int          mem_cnt     = 0;
   logic [31:0] mem_addr    = '0;
   int          hs_count    = 0;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory: responds mem_lat cycles after an accepted request with addr ^ A5A5_0000.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
   end

   always @(negedge clk) begin
      logic [31:0] e;
      imem_rsp_valid = 1'b0;
      if (mem_pending) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
            mem_pending    = 0;
         end
      end
      if (rst && imem_req_valid && imem_req_ready) begin
         hs_count++;
         mem_pending = 1;
         mem_cnt     = mem_lat;
         mem_addr    = imem_req_addr;
         total++;
         if (exp_req.size() == 0) begin
            bad++;
            $display("FAIL req_addr: got %h, no request expected", imem_req_addr);
         end else begin
            e = exp_req.pop_front();
            if (imem_req_addr !== e) begin
               bad++;
               $display("FAIL req_addr: got %h want %h", imem_req_addr, e);
            end
         end
      end
   end

   // Output monitor: compares every decode handshake against the scoreboard.
   always @(negedge clk) begin
      logic [63:0] e;
      #2;
      if (rst && out_valid && out_ready) begin
         total++;
         if (exp_out.size() == 0) begin
            bad++;
            $display("FAIL out_entry: got pc=%h instr=%h, none expected", out_pc, out_instr);
         end else begin
            e = exp_out.pop_front();
            if ({out_pc, out_instr} !== e) begin
               bad++;
               $display("FAIL out_entry: got pc=%h instr=%h want pc=%h instr=%h",
                        out_pc, out_instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic expect_out(input logic [31:0] pc);
      exp_out.push_back({pc, pc ^ 32'hA5A5_0000});
   endtask

   task automatic apply_reset(input logic ordy);
      rst            = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      out_ready      = ordy;
      mem_lat        = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Returns one step after the posedge that accepted a request to addr.
   task automatic wait_req(input logic [31:0] addr);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && imem_req_addr == addr) found = 1;
      end
      @(posedge clk);
      #1;
      if (!found) begin
         total++;
         bad++;
         $display("FAIL wait_req: got no request, want addr %h", addr);
      end
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         if (exp_out.size() == 0 && exp_req.size() == 0 && !mem_pending) done = 1;
      end
      #1;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_drain: got out_left=%0d req_left=%0d want 0/0",
                  name, exp_out.size(), exp_req.size());
      end
   endtask

   initial begin
      int hs0;
      rst            = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;

      // Streaming from reset with a 1-cycle memory
      foreach (exp_req[i]) exp_req.delete(i);
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      expect_out(32'h0);
      expect_out(32'h4);
      expect_out(32'h8);
      apply_reset(1'b1);
      @(negedge clk); #2;
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      @(negedge clk); #2;
      check("lat_cycle1_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); #2;
      check("lat_cycle2_out_valid", {31'd0, out_valid}, 32'd1);
      wait_req(32'h8);
      halt = 1'b1;
      drain("stream");

      // Backpressure: two entries fill the FIFO and fetching stalls
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      expect_out(32'h0);
      expect_out(32'h4);
      expect_out(32'h8);
      hs0 = hs_count;
      apply_reset(1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("bp_req_count", 32'(hs_count - hs0), 32'd2);
      check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      exp_req.push_back(32'h8);
      out_ready = 1'b1;
      wait_req(32'h8);
      halt = 1'b1;
      drain("bp");

      // Redirect while a slow request to 8 is outstanding
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'h40);
      expect_out(32'h0);
      expect_out(32'h4);
      expect_out(32'h40);
      apply_reset(1'b1);
      mem_lat = 3;
      wait_req(32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0043;
      @(negedge clk); #2;
      check("redir_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk); #2;
      check("redir_drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
      wait_req(32'h40);
      halt = 1'b1;
      drain("redir");

      // Redirect coinciding with a response and an attempted pop
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h100);
      expect_out(32'h100);
      apply_reset(1'b0);
      wait_req(32'h4);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      out_ready      = 1'b1;
      @(negedge clk); #2;
      check("coinc_out_gated", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk); #2;
      check("coinc_next_out_valid", {31'd0, out_valid}, 32'd0);
      check("coinc_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("coinc_req_addr", imem_req_addr, 32'h100);
      @(posedge clk); #1;
      halt = 1'b1;
      drain("coinc");

      // Halt right after the request to 12 is accepted
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      expect_out(32'h0);
      expect_out(32'h4);
      expect_out(32'h8);
      expect_out(32'hC);
      apply_reset(1'b1);
      wait_req(32'hC);
      halt = 1'b1;
      hs0  = hs_count;
      repeat (8) @(posedge clk);
      #1;
      check("halt_no_new_req", 32'(hs_count - hs0), 32'd0);
      check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("halt_delivered", 32'(exp_out.size()), 32'd0);
      exp_req.push_back(32'h10);
      expect_out(32'h10);
      halt = 1'b0;
      wait_req(32'h10);
      halt = 1'b1;
      drain("halt");

      // Async reset mid-WAIT followed by a stale response
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      expect_out(32'h0);
      apply_reset(1'b1);
      wait_req(32'h0);
      mem_lat = 3;
      wait_req(32'h4);
      imem_req_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("areset_req_addr", imem_req_addr, 32'h0);
      check("areset_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk); #2;
      check("stale_not_pushed", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      exp_req.push_back(32'h0);
      expect_out(32'h0);
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      wait_req(32'h0);
      halt = 1'b1;
      drain("stale");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that replaces the free-running PC-plus-InstMem pairing ahead of the IF/ID register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake; honours redirects from the branch/jump resolution stage and a halt from endProgram.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request address valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  XLEN  instruction word.
- redirect_valid  input  1  taken branch/jump; flush and refetch.
- redirect_pc  input  XLEN  new fetch target.
- halt  input  1  stop issuing new requests (endProgram).
- out_valid  output  1  {out_pc, out_instr} valid for decode.
- out_ready  input  1  decode consumes entry.
- out_pc  output  XLEN  PC of presented instruction.
- out_instr  output  XLEN  presented instruction.

Behaviour:
- Reset: rst low asynchronously clears state to REQ, fetch_pc=RESET_PC, FIFO count/pointers 0, outstanding 0.
- Reset outputs: imem_req_valid=1 once rst is released (REQ state, FIFO has space), imem_req_addr=RESET_PC, out_valid=0; out_pc/out_instr=0.
- Handshakes: request handshake = imem_req_valid & imem_req_ready; output handshake = out_valid & out_ready.
- At most one outstanding request.
- imem_rsp_valid is never accepted in the same cycle as the corresponding request handshake; the earliest response is the next cycle.
- Space rule: imem_req_valid = (state==REQ) & !halt & !redirect_valid & (count < FIFO_DEPTH); the outstanding request is counted against space.
- imem_req_valid may drop before ready arrives (halt/redirect); the memory must ignore unaccepted requests.
- State REQ: on request handshake, go to WAIT; fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0.
- State WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_data} into the FIFO and return to REQ; req_pc is latched at the request handshake.
- State DRAIN: the next imem_rsp_valid is discarded (no push), then go to REQ.
- State REQ: imem_rsp_valid with nothing outstanding is ignored, e.g. a stale response after reset mid-operation.
- Redirect has priority over every other event in the cycle:
  - FIFO flushed (count 0 next cycle).
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Next state is DRAIN if in WAIT without imem_rsp_valid this cycle; otherwise REQ. A response arriving in the redirect cycle is discarded.
  - out_valid is forced to 0 combinationally while redirect_valid=1; a pop in that cycle has no effect.
  - A redirect while in DRAIN stays in DRAIN.
- Halt: blocks new requests only. An outstanding response still completes and the FIFO still drains. Deasserting halt resumes from fetch_pc.
- FIFO output: out_valid = (count!=0) & !redirect_valid; out_pc/out_instr show the head entry.
- FIFO push and pop in the same cycle are both permitted, including when full-minus-one or with one entry.
- Push when full cannot occur under the space rule; the assertion bench flags it.
- Latency: an empty FIFO with a 1-cycle memory gives request at cycle N, response at N+1, out_valid at N+2.
- Throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding).

Decomposition:
- defines.v gets:
  - state encodings FETCH_REQ=2'd0, FETCH_WAIT=2'd1, FETCH_DRAIN=2'd2.
  - default RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO, parameters WIDTH=2*XLEN and DEPTH.
  - Inputs: push, pop, flush (flush dominates).
  - Outputs: head data, count.
  - Reset: same async active-low rst.
- fetch_unit holds the FSM, fetch_pc, req_pc and the output gating.

Test Plan:
- Reset release, memory always ready with 1-cycle response returning addr^32'hA5A5_0000, out_ready=1 -> imem_req_addr sequence 0,4,8,…; out_pc 0,4,8 with out_instr 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008; first out_valid 2 cycles after first handshake.
- out_ready=0 for 10 cycles -> requests stop once count reaches 2 (addresses 0 and 4 only). Raising out_ready yields 0 then 4 in order, then fetching resumes at 8.
- Redirect to 32'h0000_0043 while a request to 8 is outstanding with 3-cycle latency -> response for 8 discarded, FIFO empty. Next request addr 32'h0000_0040, next out_pc 32'h40.
- Redirect in the same cycle as imem_rsp_valid and as an out_ready pop -> response dropped, pop ignored, out_valid=0 the next cycle, next request at the redirect target.
- Assert halt at the cycle a request to 12 is accepted -> response for 12 still delivered, no further imem_req_valid. Releasing halt resumes at 16.
- Async rst low mid-WAIT, then a stale imem_rsp_valid after release -> stale data not pushed, first out_pc = RESET_PC.
